fast_bconv_multilane: RTL and testbench

Next-generation fast base conversion for a full RNS polynomial: converts N_SLOTS coefficients from the input basis {q_i} to the target basis {b_j}. It computes sum_i [x_i*z_i mod q_i]*(q/q_i mod b_j) mod b_j, without the q-overflow correction. A single shared controller drives all slots, consuming TERMS_PER_CYCLE input-basis terms per cycle. The block has valid/ready handshakes on both sides, an output hold under back-pressure, and a synchronous abort. It sits between the NTT/RNS datapath and ModUp/ModDown stages.

---
 rtl/fast_bconv_multilane_pkg.sv | 22 ++
 rtl/fast_bconv_lane.sv | 68 ++++++
 rtl/fast_bconv_multilane.sv | 130 +++++++++++++
 tb/tb_fast_bconv_multilane.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fast_bconv_multilane_pkg.sv
// Shared types, state encoding and constant helpers for the multi-lane RNS fast base converter.
package fast_bconv_multilane_pkg;
  localparam int RNS_PRIME_BITS  = 16;
  localparam int DEFAULT_N_SLOTS = 4;

  typedef logic [RNS_PRIME_BITS-1:0]   rns_residue_t;
  typedef logic [2*RNS_PRIME_BITS-1:0] wide_rns_residue_t;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} bconv_state_t;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  // Full-width product followed by a true modulo; operands are always residues.
  function automatic rns_residue_t mulmod(input rns_residue_t a, input rns_residue_t b,
                                          input rns_residue_t m);
    wide_rns_residue_t p;
    p = wide_rns_residue_t'(a) * wide_rns_residue_t'(b);
    return rns_residue_t'(p % wide_rns_residue_t'(m));
  endfunction
endpackage

// File: rtl/fast_bconv_lane.sv
// Per-slot datapath: a-register latch, P-term reduce tree for the current beat, M target accumulators.
// Driven entirely by the shared controller (load/clear/step/beat); no local control state.
module fast_bconv_lane
  import fast_bconv_multilane_pkg::*;
#(
  parameter int L      = 3,
  parameter int M      = 2,
  parameter int P      = 1,
  parameter int BEAT_W = 1,
  parameter rns_residue_t IN_BASIS  [L]    = '{3, 5, 7},
  parameter rns_residue_t OUT_BASIS [M]    = '{11, 13},
  parameter rns_residue_t ZILUT     [L]    = '{2, 1, 1},
  parameter rns_residue_t YMODB     [M][L] = '{'{2, 10, 4}, '{9, 8, 2}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic              step,
  input  logic [BEAT_W-1:0] beat,
  input  rns_residue_t      x   [L],
  output rns_residue_t      acc [M]
);
  localparam int SUM_W = RNS_PRIME_BITS + $clog2(P + 1);

  rns_residue_t     a       [L];
  rns_residue_t     a_nxt   [L];
  logic [SUM_W-1:0] beat_sum[M];
  rns_residue_t     acc_nxt [M];

  always_comb begin
    for (int i = 0; i < L; i++) begin
      a_nxt[i] = mulmod(x[i], ZILUT[i], IN_BASIS[i]);
    end
  end

  // Terms with index >= L simply never match, so padded beats add zero.
  always_comb begin
    for (int j = 0; j < M; j++) begin
      beat_sum[j] = '0;
      for (int t = 0; t < P; t++) begin
        for (int i = 0; i < L; i++) begin
          if (i == int'(beat) * P + t) begin
            beat_sum[j] = beat_sum[j] + SUM_W'(mulmod(a[i], YMODB[j][i], OUT_BASIS[j]));
          end
        end
      end
      acc_nxt[j] = rns_residue_t'((wide_rns_residue_t'(acc[j]) + wide_rns_residue_t'(beat_sum[j]))
                                  % wide_rns_residue_t'(OUT_BASIS[j]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < L; i++) a[i] <= '0;
      for (int j = 0; j < M; j++) acc[j] <= '0;
    end else begin
      if (load) begin
        for (int i = 0; i < L; i++) a[i] <= a_nxt[i];
      end
      if (clear) begin
        for (int j = 0; j < M; j++) acc[j] <= '0;
      end else if (step) begin
        for (int j = 0; j < M; j++) acc[j] <= acc_nxt[j];
      end
    end
  end
endmodule

// File: rtl/fast_bconv_multilane.sv
// Fast base conversion of N_SLOTS coefficients; out_valid rises ceil(L/P) edges after acceptance.
// Result is held in DONE until out_ready; abort returns to IDLE from any busy state.
module fast_bconv_multilane
  import fast_bconv_multilane_pkg::*;
#(
  parameter int IN_BASIS_LEN    = 3,
  parameter int OUT_BASIS_LEN   = 2,
  parameter int N_SLOTS         = DEFAULT_N_SLOTS,
  parameter int TERMS_PER_CYCLE = 1,
  parameter rns_residue_t IN_BASIS  [IN_BASIS_LEN]                = '{3, 5, 7},
  parameter rns_residue_t OUT_BASIS [OUT_BASIS_LEN]               = '{11, 13},
  parameter rns_residue_t ZiLUT     [IN_BASIS_LEN]                = '{2, 1, 1},
  parameter rns_residue_t YMODB     [OUT_BASIS_LEN][IN_BASIS_LEN] = '{'{2, 10, 4}, '{9, 8, 2}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  rns_residue_t input_RNSpoly  [N_SLOTS][IN_BASIS_LEN],
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output rns_residue_t output_RNSpoly [N_SLOTS][OUT_BASIS_LEN],
  output logic         busy
);
  localparam int P_SAFE = (TERMS_PER_CYCLE < 1) ? 1 : TERMS_PER_CYCLE;
  localparam int NBEATS = ceil_div(IN_BASIS_LEN, P_SAFE);
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  if (TERMS_PER_CYCLE < 1 || TERMS_PER_CYCLE > IN_BASIS_LEN) begin : g_bad_p
    $fatal(1, "fast_bconv_multilane: TERMS_PER_CYCLE must be in 1..IN_BASIS_LEN");
  end
  for (genvar i = 0; i < IN_BASIS_LEN; i++) begin : g_chk_in
    if (IN_BASIS[i] == '0 || ZiLUT[i] == '0) begin : g_bad
      $fatal(1, "fast_bconv_multilane: zero IN_BASIS/ZiLUT entry");
    end
  end
  for (genvar j = 0; j < OUT_BASIS_LEN; j++) begin : g_chk_out
    if (OUT_BASIS[j] == '0) begin : g_bad
      $fatal(1, "fast_bconv_multilane: zero OUT_BASIS entry");
    end
  end

  bconv_state_t      state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              load, clear, step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // abort is checked first in every busy state so it outranks out_ready and the step.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    load    = 1'b0;
    clear   = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          clear   = 1'b1;
          beat_d  = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (abort) begin
          clear   = 1'b1;
          beat_d  = '0;
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (beat_q == BEAT_W'(NBEATS - 1)) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (abort) begin
          clear   = 1'b1;
          state_d = IDLE;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        clear   = 1'b1;
        beat_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  for (genvar s = 0; s < N_SLOTS; s++) begin : g_lane
    fast_bconv_lane #(
      .L        (IN_BASIS_LEN),
      .M        (OUT_BASIS_LEN),
      .P        (P_SAFE),
      .BEAT_W   (BEAT_W),
      .IN_BASIS (IN_BASIS),
      .OUT_BASIS(OUT_BASIS),
      .ZILUT    (ZiLUT),
      .YMODB    (YMODB)
    ) u_lane (
      .clk  (clk),
      .rst  (reset),
      .load (load),
      .clear(clear),
      .step (step),
      .beat (beat_q),
      .x    (input_RNSpoly[s]),
      .acc  (output_RNSpoly[s])
    );
  end
endmodule

// File: tb/tb_fast_bconv_multilane.sv
// Self-checking bench: scoreboard of expected polynomials, directed and randomised conversions.
module tb_fast_bconv_multilane;
  import fast_bconv_multilane_pkg::*;

  localparam int NS = 4;
  typedef logic [NS-1:0][2:0][15:0] ipoly_t;
  typedef logic [NS-1:0][1:0][15:0] opoly_t;

  localparam int Q [3]    = '{3, 5, 7};
  localparam int B [2]    = '{11, 13};
  localparam int Z [3]    = '{2, 1, 1};
  localparam int Y [2][3] = '{'{2, 10, 4}, '{9, 8, 2}};

  logic clk, reset;
  logic in_valid, in_ready, abort, out_valid, out_ready, busy;
  logic iv2, ir2, ov2, bz2, iv3, ir3, ov3, bz3;
  logic abort23, ordy23;
  ipoly_t in_poly;
  rns_residue_t in_rns [NS][3];
  rns_residue_t out1 [NS][2];
  rns_residue_t out2 [NS][2];
  rns_residue_t out3 [NS][2];
  opoly_t out1_f, out2_f, out3_f;

  int checks = 0;
  int errors = 0;
  opoly_t sb[$];

  fast_bconv_multilane #(.N_SLOTS(NS), .TERMS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .input_RNSpoly(in_rns), .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
    .output_RNSpoly(out1), .busy(busy));
  fast_bconv_multilane #(.N_SLOTS(NS), .TERMS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2),
    .input_RNSpoly(in_rns), .abort(abort23), .out_valid(ov2), .out_ready(ordy23),
    .output_RNSpoly(out2), .busy(bz2));
  fast_bconv_multilane #(.N_SLOTS(NS), .TERMS_PER_CYCLE(3)) u_dut3 (
    .clk(clk), .reset(reset), .in_valid(iv3), .in_ready(ir3),
    .input_RNSpoly(in_rns), .abort(abort23), .out_valid(ov3), .out_ready(ordy23),
    .output_RNSpoly(out3), .busy(bz3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int s = 0; s < NS; s++) begin
      for (int i = 0; i < 3; i++) in_rns[s][i] = in_poly[s][i];
      for (int j = 0; j < 2; j++) begin
        out1_f[s][j] = out1[s][j];
        out2_f[s][j] = out2[s][j];
        out3_f[s][j] = out3[s][j];
      end
    end
  end

  function automatic ipoly_t from_ints(input int x0, input int x1, input int x2, input int x3);
    int xs [NS];
    ipoly_t p;
    xs = '{x0, x1, x2, x3};
    for (int s = 0; s < NS; s++)
      for (int i = 0; i < 3; i++) p[s][i] = 16'(xs[s] % Q[i]);
    return p;
  endfunction

  function automatic opoly_t model(input ipoly_t r);
    opoly_t o;
    for (int s = 0; s < NS; s++) begin
      for (int j = 0; j < 2; j++) begin
        int acc;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
          int a;
          a = (int'(r[s][i]) * Z[i]) % Q[i];
          acc += (a * Y[j][i]) % B[j];
        end
        o[s][j] = 16'(acc % B[j]);
      end
    end
    return o;
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = 0; abort = 0; out_ready = 0; iv2 = 0; iv3 = 0;
    abort23 = 0; ordy23 = 1; in_poly = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (out1_f !== '0) begin errors++; $display("FAIL reset_output got=%h want=0", out1_f); end
    checks++; if ({ir2, ir3, bz2, bz3, ov2, ov3} !== 6'b110000) begin
      errors++; $display("FAIL reset_p23_ctrl got=%b want=110000", {ir2, ir3, bz2, bz3, ov2, ov3});
    end
  endtask

  task automatic test_basic();
    ipoly_t p;
    opoly_t got;
    logic [1:0][15:0] e0;
    int lat;
    p = from_ints(10, 104, 0, int'($urandom_range(0, 104)));
    sb.push_back(model(p));
    in_poly = p; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_poly = '1;
    checks++; if ({busy, in_ready} !== 2'b10) begin errors++; $display("FAIL basic_busy got=%b want=10", {busy, in_ready}); end
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency got=%0d want=3", lat); end
    e0[0] = 16'd5; e0[1] = 16'd11;
    checks++; if (out1_f[0] !== e0) begin errors++; $display("FAIL basic_x10 got=%h want=%h", out1_f[0], e0); end
    e0[0] = 16'd0; e0[1] = 16'd1;
    checks++; if (out1_f[1] !== e0) begin errors++; $display("FAIL basic_x104 got=%h want=%h", out1_f[1], e0); end
    checks++; if (out1_f[2] !== '0) begin errors++; $display("FAIL basic_x0 got=%h want=0", out1_f[2]); end
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL basic_sb got=empty want=entry"); end
    else begin
      got = sb.pop_front();
      if (out1_f !== got) begin errors++; $display("FAIL basic_poly got=%h want=%h", out1_f, got); end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL basic_release got=%b want=01", {out_valid, in_ready}); end
    checks++; if (out1_f !== got) begin errors++; $display("FAIL basic_held got=%h want=%h", out1_f, got); end
  endtask

  task automatic test_terms_per_cycle();
    ipoly_t p;
    opoly_t exp2, exp3;
    logic [1:0][15:0] e0;
    int l2, l3;
    p = from_ints(10, 10, 104, 33);
    sb.push_back(model(p));
    sb.push_back(model(p));
    in_poly = p; iv2 = 1'b1; iv3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv2 = 1'b0; iv3 = 1'b0; in_poly = '0;
    l2 = -1; l3 = -1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (ov2 && l2 < 0) begin l2 = n; exp2 = out2_f; end
      if (ov3 && l3 < 0) begin l3 = n; exp3 = out3_f; end
    end
    checks++; if (l2 !== 2) begin errors++; $display("FAIL p2_latency got=%0d want=2", l2); end
    checks++; if (l3 !== 1) begin errors++; $display("FAIL p3_latency got=%0d want=1", l3); end
    e0[0] = 16'd5; e0[1] = 16'd11;
    checks++; if (exp2[0] !== e0) begin errors++; $display("FAIL p2_x10 got=%h want=%h", exp2[0], e0); end
    checks++; if (exp2 !== sb.pop_front()) begin errors++; $display("FAIL p2_poly got=%h", exp2); end
    checks++; if (exp3 !== sb.pop_front()) begin errors++; $display("FAIL p3_poly got=%h", exp3); end
  endtask

  task automatic test_backpressure();
    ipoly_t p;
    opoly_t got;
    logic [1:0][15:0] e0;
    int lat;
    p = from_ints(10, 10, 10, 10);
    sb.push_back(model(p));
    in_poly = p; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
    checks++; if (!out_valid) begin errors++; $display("FAIL bp_timeout got=no out_valid want=out_valid"); end
    got = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_poly = from_ints(104, 104, 104, 104);
      checks++;
      if ({out_valid, in_ready} !== 2'b10 || out1_f !== got) begin
        errors++; $display("FAIL bp_hold cyc=%0d vr=%b got=%h want=%h", c, {out_valid, in_ready}, out1_f, got);
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if ({out_valid, in_ready, busy} !== 3'b010) begin errors++; $display("FAIL bp_release got=%b want=010", {out_valid, in_ready, busy}); end
    p = from_ints(104, 104, 104, 104);
    sb.push_back(model(p));
    in_poly = p; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
    e0[0] = 16'd0; e0[1] = 16'd1;
    checks++; if (!out_valid || out1_f[3] !== e0) begin errors++; $display("FAIL bp_next got=%h want=%h", out1_f[3], e0); end
    got = sb.pop_front();
    checks++; if (out1_f !== got) begin errors++; $display("FAIL bp_next_poly got=%h want=%h", out1_f, got); end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_abort();
    ipoly_t p;
    opoly_t got;
    logic [1:0][15:0] e0;
    int seen, lat;
    in_poly = from_ints(7, 8, 9, 104); in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    checks++; if ({busy, in_ready, out_valid} !== 3'b010) begin errors++; $display("FAIL abort_state got=%b want=010", {busy, in_ready, out_valid}); end
    checks++; if (out1_f !== '0) begin errors++; $display("FAIL abort_clear got=%h want=0", out1_f); end
    seen = 0;
    repeat (6) begin @(posedge clk); @(negedge clk); if (out_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_valid got=%0d want=0", seen); end
    p = from_ints(10, 10, 10, 10);
    sb.push_back(model(p));
    in_poly = p; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
    e0[0] = 16'd5; e0[1] = 16'd11;
    checks++; if (!out_valid || out1_f[0] !== e0) begin errors++; $display("FAIL abort_next got=%h want=%h", out1_f[0], e0); end
    got = sb.pop_front();
    checks++; if (out1_f !== got) begin errors++; $display("FAIL abort_next_poly got=%h want=%h", out1_f, got); end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    in_poly = from_ints(10, 104, 50, 77); in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL areset_ctrl got=%b want=00", {out_valid, busy}); end
    checks++; if (out1_f !== '0) begin errors++; $display("FAIL areset_output got=%h want=0", out1_f); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL areset_release got=%b want=10", {in_ready, out_valid}); end
  endtask

  task automatic test_back_to_back();
    ipoly_t p;
    opoly_t got;
    int lat, hold;
    for (int n = 0; n < 12; n++) begin
      for (int s = 0; s < NS; s++)
        for (int i = 0; i < 3; i++)
          p[s][i] = (n == 0) ? 16'(Q[i] - 1) : 16'($urandom_range(0, Q[i] - 1));
      sb.push_back(model(p));
      in_poly = p; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin @(posedge clk); lat++; @(negedge clk); end
      hold = int'($urandom_range(0, 3));
      repeat (hold) begin @(posedge clk); @(negedge clk); end
      got = sb.pop_front();
      checks++;
      if (!out_valid || lat !== 3 || out1_f !== got) begin
        errors++; $display("FAIL b2b_%0d v=%b lat=%0d got=%h want=%h", n, out_valid, lat, out1_f, got);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
    end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL sb_drain got=%0d want=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_terms_per_cycle();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
